// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, exception codes, field positions.
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_DIV0 = 5'd13;

  localparam int ST_IE   = 0;
  localparam int ST_EXL  = 1;
  localparam int IM_LO   = 10;
  localparam int IP_LO   = 10;
  localparam int CODE_LO = 2;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_F000;

  typedef struct packed {
    logic ri;
    logic ov;
    logic div0;
    logic sys;
    logic bp;
    logic eret;
  } exc_flags_t;

  function automatic logic [31:0] status_word(logic [5:0] im, logic exl, logic ie);
    logic [31:0] w;
    w = '0;
    w[IM_LO +: 6] = im;
    w[ST_EXL]     = exl;
    w[ST_IE]      = ie;
    return w;
  endfunction

  function automatic logic [31:0] cause_word(logic [5:0] ip, logic [4:0] code);
    logic [31:0] w;
    w = '0;
    w[IP_LO +: 6]   = ip;
    w[CODE_LO +: 5] = code;
    return w;
  endfunction

endpackage

// File: rtl/cp0_if.sv
// Writeback-stage to CP0 bus: instruction info and event flags in, control/data out.
interface cp0_if;
  logic        WB_valid;
  logic [31:0] WB_PC;
  logic [31:0] WB_rd;
  logic [31:0] WB_rt_value;
  logic        WB_Overflow;
  logic        WB_Divide_zero;
  logic        WB_Syscall;
  logic        WB_Break;
  logic        WB_Eret;
  logic        WB_Reserved_instruction;
  logic        WB_Mfc0;
  logic        WB_Mtc0;
  logic [5:0]  ext_int;
  logic [31:0] cp0_rdata;
  logic        exc_flush;
  logic        wb_cancel;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        cp0_backFromEret;

  modport master (
    output WB_valid, WB_PC, WB_rd, WB_rt_value, WB_Overflow, WB_Divide_zero,
           WB_Syscall, WB_Break, WB_Eret, WB_Reserved_instruction, WB_Mfc0,
           WB_Mtc0, ext_int,
    input  cp0_rdata, exc_flush, wb_cancel, pc_redirect, redirect_pc,
           cp0_backFromEret
  );

  modport slave (
    input  WB_valid, WB_PC, WB_rd, WB_rt_value, WB_Overflow, WB_Divide_zero,
           WB_Syscall, WB_Break, WB_Eret, WB_Reserved_instruction, WB_Mfc0,
           WB_Mtc0, ext_int,
    output cp0_rdata, exc_flush, wb_cancel, pc_redirect, redirect_pc,
           cp0_backFromEret
  );
endinterface

// File: rtl/cp0_exc_prio.sv
// Picks the single event taken in WB: Int > RI > Ov > Div0 > Sys > Bp, then eret.
module cp0_exc_prio
  import cp0_pkg::*;
(
  input  logic       valid,
  input  logic       int_pend,
  input  exc_flags_t flags,
  output logic       taken,
  output logic       is_eret,
  output logic [4:0] exccode
);

  always_comb begin
    taken   = 1'b0;
    exccode = EXC_INT;
    if (valid) begin
      taken = 1'b1;
      if (int_pend)        exccode = EXC_INT;
      else if (flags.ri)   exccode = EXC_RI;
      else if (flags.ov)   exccode = EXC_OV;
      else if (flags.div0) exccode = EXC_DIV0;
      else if (flags.sys)  exccode = EXC_SYS;
      else if (flags.bp)   exccode = EXC_BP;
      else                 taken   = 1'b0;
    end
  end

  assign is_eret = valid & flags.eret & ~taken;

endmodule

// File: rtl/cp0_unit.sv
// CP0 coprocessor: Count/Compare/Status/Cause/EPC plus WB-stage exception and eret control.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic  clock,
  input  logic  reset,
  cp0_if.slave  bus
);

  logic [31:0] count_q, compare_q, epc_q;
  logic [5:0]  im_q, ip_q;
  logic        exl_q, ie_q, timer_pending_q, back_q;
  logic [4:0]  exccode_q;

  logic [4:0]  idx;
  logic        unused_rd_hi;
  exc_flags_t  flags;
  logic        int_pend, taken, is_eret;
  logic [4:0]  exccode;
  logic        mtc0_we, wr_count, wr_compare, wr_status, wr_epc;
  logic [31:0] rd_val;

  assign idx          = bus.WB_rd[4:0];
  assign unused_rd_hi = ^bus.WB_rd[31:5];

  assign flags = '{ri:   bus.WB_Reserved_instruction,
                   ov:   bus.WB_Overflow,
                   div0: bus.WB_Divide_zero,
                   sys:  bus.WB_Syscall,
                   bp:   bus.WB_Break,
                   eret: bus.WB_Eret};

  assign int_pend = ie_q & ~exl_q & (|(ip_q & im_q)) & bus.WB_valid;

  cp0_exc_prio u_prio (
    .valid    (bus.WB_valid),
    .int_pend (int_pend),
    .flags    (flags),
    .taken    (taken),
    .is_eret  (is_eret),
    .exccode  (exccode)
  );

  // A taken exception kills the instruction, so its mtc0 never lands.
  assign mtc0_we    = bus.WB_valid & bus.WB_Mtc0 & ~taken;
  assign wr_count   = mtc0_we && (idx == CP0_COUNT);
  assign wr_compare = mtc0_we && (idx == CP0_COMPARE);
  assign wr_status  = mtc0_we && (idx == CP0_STATUS);
  assign wr_epc     = mtc0_we && (idx == CP0_EPC);

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q         <= '0;
      compare_q       <= '0;
      epc_q           <= '0;
      im_q            <= '0;
      ip_q            <= '0;
      exl_q           <= 1'b0;
      ie_q            <= 1'b0;
      exccode_q       <= '0;
      timer_pending_q <= 1'b0;
      back_q          <= 1'b0;
    end else begin
      count_q <= wr_count ? bus.WB_rt_value : count_q + 32'd1;
      if (wr_compare) compare_q <= bus.WB_rt_value;
      // Rewriting Compare acknowledges the timer even if it matches this cycle.
      if (wr_compare)                  timer_pending_q <= 1'b0;
      else if (count_q == compare_q)   timer_pending_q <= 1'b1;
      ip_q <= {bus.ext_int[5] | timer_pending_q, bus.ext_int[4:0]};
      if (wr_status) begin
        im_q  <= bus.WB_rt_value[IM_LO +: 6];
        exl_q <= bus.WB_rt_value[ST_EXL];
        ie_q  <= bus.WB_rt_value[ST_IE];
      end
      // Hardware EXL update follows the mtc0 so it wins on the same edge.
      if (taken) begin
        exl_q     <= 1'b1;
        exccode_q <= exccode;
      end else if (is_eret) begin
        exl_q <= 1'b0;
      end
      if (taken && !exl_q) epc_q <= bus.WB_PC;
      else if (wr_epc)     epc_q <= bus.WB_rt_value;
      back_q <= is_eret;
    end
  end

  always_comb begin
    rd_val = '0;
    case (idx)
      CP0_COUNT:   rd_val = count_q;
      CP0_COMPARE: rd_val = compare_q;
      CP0_STATUS:  rd_val = status_word(im_q, exl_q, ie_q);
      CP0_CAUSE:   rd_val = cause_word(ip_q, exccode_q);
      CP0_EPC:     rd_val = epc_q;
      default:     rd_val = '0;
    endcase
  end

  assign bus.cp0_rdata        = (!reset && bus.WB_Mfc0) ? rd_val : '0;
  assign bus.exc_flush        = ~reset & (taken | is_eret);
  assign bus.wb_cancel        = ~reset & taken;
  assign bus.pc_redirect      = ~reset & (taken | is_eret);
  assign bus.redirect_pc      = reset   ? '0 :
                                taken   ? EXC_VECTOR :
                                is_eret ? epc_q : '0;
  assign bus.cp0_backFromEret = back_q;

endmodule
